quad_counter: RTL and testbench

Position and velocity stage directly downstream of the quadrature decoder. Consumes the decoder's combined 4X pulse (`enc_out`) and direction (`enc_dir`), and maintains a signed position count: one step per `enc_out` transition, up when forward, down when reverse. It also provides a host snapshot of the count and, when compiled in, a per-window signed velocity measurement. It feeds the peripheral's register interface.

---
 rtl/quad_counter_if.sv | 26 ++
 rtl/quad_counter.sv | 116 +++++++++++
 tb/tb_quad_counter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/quad_counter_if.sv
// Signal bundle between the quadrature decoder/host side and quad_counter.
// master drives the decoder and host controls; slave is the counter.
interface quad_counter_if #(
    parameter int CNT_WIDTH = 16,
    parameter int VEL_WIDTH = 16
);
    logic                 enc_out;
    logic                 enc_dir;
    logic                 clear;
    logic                 latch_req;
    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] count_latched;
    logic                 latch_valid;
    logic [VEL_WIDTH-1:0] velocity;
    logic                 vel_valid;

    modport master (
        output enc_out, enc_dir, clear, latch_req,
        input  count, count_latched, latch_valid, velocity, vel_valid
    );

    modport slave (
        input  enc_out, enc_dir, clear, latch_req,
        output count, count_latched, latch_valid, velocity, vel_valid
    );
endinterface

// File: rtl/quad_counter.sv
// Signed position counter with host snapshot for a 4X quadrature pulse stream.
// Define QUAD_VELOCITY_EN to add the windowed, saturating velocity measurement.
module quad_counter #(
    parameter int CNT_WIDTH  = 16,
    parameter int VEL_PERIOD = 50000,
    parameter int VEL_WIDTH  = 16
) (
    input logic           clk,
    input logic           reset,
    quad_counter_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0] CntOne = 1;

    logic                 enc_prev;
    logic                 step;
    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;
    logic [CNT_WIDTH-1:0] latched_q;
    logic                 latch_valid_q;

    assign step = (bus.enc_out != enc_prev);

    always_comb begin
        count_d = count_q;
        if (bus.clear) begin
            count_d = '0;
        end else if (step) begin
            count_d = bus.enc_dir ? (count_q - CntOne) : (count_q + CntOne);
        end
    end

    // enc_prev tracks even under clear so a dropped edge is never counted later.
    always_ff @(posedge clk) begin
        if (reset) begin
            enc_prev      <= 1'b0;
            count_q       <= '0;
            latched_q     <= '0;
            latch_valid_q <= 1'b0;
        end else begin
            enc_prev      <= bus.enc_out;
            count_q       <= count_d;
            latch_valid_q <= bus.latch_req;
            if (bus.latch_req) begin
                latched_q <= count_q;
            end
        end
    end

    assign bus.count         = count_q;
    assign bus.count_latched = latched_q;
    assign bus.latch_valid   = latch_valid_q;

`ifdef QUAD_VELOCITY_EN
    localparam int TW = $clog2(VEL_PERIOD);
    localparam logic [TW-1:0]      TimerOne  = 1;
    localparam logic [TW-1:0]      TimerLast = TW'(VEL_PERIOD - 1);
    localparam logic [VEL_WIDTH:0] VelOne    = 1;

    logic [TW-1:0]        timer_q;
    logic [VEL_WIDTH-1:0] acc_q;
    logic [VEL_WIDTH-1:0] vel_q;
    logic                 vel_valid_q;
    logic [VEL_WIDTH:0]   delta;
    logic [VEL_WIDTH:0]   acc_sum;
    logic [VEL_WIDTH-1:0] acc_sat;
    logic                 terminal;

    assign terminal = (timer_q == TimerLast);

    // One guard bit above acc; disagreement of the top two bits flags overflow.
    always_comb begin
        delta = '0;
        if (step) begin
            delta = bus.enc_dir ? '1 : VelOne;
        end
        acc_sum = {acc_q[VEL_WIDTH-1], acc_q} + delta;
        if (acc_sum[VEL_WIDTH] != acc_sum[VEL_WIDTH-1]) begin
            acc_sat = acc_sum[VEL_WIDTH] ? {1'b1, {(VEL_WIDTH-1){1'b0}}}
                                         : {1'b0, {(VEL_WIDTH-1){1'b1}}};
        end else begin
            acc_sat = acc_sum[VEL_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q     <= '0;
            acc_q       <= '0;
            vel_q       <= '0;
            vel_valid_q <= 1'b0;
        end else if (bus.clear) begin
            timer_q     <= '0;
            acc_q       <= '0;
            vel_valid_q <= 1'b0;
        end else if (terminal) begin
            timer_q     <= '0;
            acc_q       <= '0;
            vel_q       <= acc_sat;
            vel_valid_q <= 1'b1;
        end else begin
            timer_q     <= timer_q + TimerOne;
            acc_q       <= acc_sat;
            vel_valid_q <= 1'b0;
        end
    end

    assign bus.velocity  = vel_q;
    assign bus.vel_valid = vel_valid_q;
`else
    logic unused_vel_cfg;
    assign unused_vel_cfg = ((VEL_PERIOD + VEL_WIDTH) > 0);

    assign bus.velocity  = '0;
    assign bus.vel_valid = 1'b0;
`endif
endmodule

// File: tb/tb_quad_counter.sv
// Scoreboard bench for quad_counter: stimulus queues expected results per cycle,
// a negedge monitor pops and compares them against count, snapshot and velocity.
module tb_quad_counter;
    localparam int CW = 16;
    localparam int VW = 16;
    localparam int VP = 100;

    typedef struct {
        int          due;
        int          kind;
        logic [15:0] val;
        int          tag;
    } exp_t;

    exp_t cq[$];
    exp_t lq[$];
    exp_t vq[$];

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    bit   vel_track;
    int   c0;

    quad_counter_if #(.CNT_WIDTH(CW), .VEL_WIDTH(VW)) bus ();

    quad_counter #(
        .CNT_WIDTH (CW),
        .VEL_PERIOD(VP),
        .VEL_WIDTH (VW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cnt(input int tag, input logic [15:0] v, input int due);
        exp_t e;
        e.due = due; e.kind = 0; e.val = v; e.tag = tag;
        cq.push_back(e);
    endtask

    task automatic push_zero(input int tag, input int due);
        exp_t e;
        e.due = due; e.kind = 1; e.val = '0; e.tag = tag;
        cq.push_back(e);
    endtask

    task automatic push_latch(input int tag, input logic [15:0] v, input int due);
        exp_t e;
        e.due = due; e.kind = 0; e.val = v; e.tag = tag;
        lq.push_back(e);
    endtask

    task automatic push_vel(input int tag, input logic [15:0] v, input int due);
        exp_t e;
        e.due = due; e.kind = 0; e.val = v; e.tag = tag;
        vq.push_back(e);
    endtask

    task automatic toggle();
        bus.enc_out = ~bus.enc_out;
    endtask

    // Monitor: compare everything due this cycle; flag missing or unexpected pulses.
    always @(negedge clk) begin
        exp_t e;
        while (cq.size() > 0 && cq[0].due <= cyc) begin
            e = cq.pop_front();
            tests++;
            if (e.due != cyc) begin
                fails++;
                $display("FAIL count_sched tag%0d: checked at cycle %0d, due %0d", e.tag, cyc, e.due);
            end else if (e.kind == 0) begin
                if (bus.count !== e.val) begin
                    fails++;
                    $display("FAIL count tag%0d: got %h, want %h", e.tag, bus.count, e.val);
                end
            end else if ({bus.count, bus.count_latched, bus.latch_valid, bus.velocity,
                          bus.vel_valid} !== '0) begin
                fails++;
                $display("FAIL all_zero tag%0d: count=%h latched=%h lv=%b vel=%h vv=%b, want 0",
                         e.tag, bus.count, bus.count_latched, bus.latch_valid, bus.velocity,
                         bus.vel_valid);
            end
        end

        if (bus.latch_valid === 1'b1) begin
            tests++;
            if (lq.size() == 0) begin
                fails++;
                $display("FAIL latch_unexpected: latch_valid=1 at cycle %0d, want 0", cyc);
            end else begin
                e = lq.pop_front();
                if (e.due != cyc || bus.count_latched !== e.val) begin
                    fails++;
                    $display("FAIL latch tag%0d: got %h at cycle %0d, want %h at cycle %0d",
                             e.tag, bus.count_latched, cyc, e.val, e.due);
                end
            end
        end
        if (lq.size() > 0 && lq[0].due < cyc) begin
            e = lq.pop_front();
            tests++;
            fails++;
            $display("FAIL latch_missing tag%0d: no latch_valid by cycle %0d, want at %0d",
                     e.tag, cyc, e.due);
        end

        if (vel_track && bus.vel_valid === 1'b1) begin
            tests++;
            if (vq.size() == 0) begin
                fails++;
                $display("FAIL vel_unexpected: vel_valid=1 at cycle %0d, want 0", cyc);
            end else begin
                e = vq.pop_front();
                if (e.due != cyc || bus.velocity !== e.val) begin
                    fails++;
                    $display("FAIL velocity tag%0d: got %h at cycle %0d, want %h at cycle %0d",
                             e.tag, bus.velocity, cyc, e.val, e.due);
                end
            end
        end
        if (vq.size() > 0 && vq[0].due < cyc) begin
            e = vq.pop_front();
            tests++;
            fails++;
            $display("FAIL vel_missing tag%0d: no vel_valid by cycle %0d, want at %0d",
                     e.tag, cyc, e.due);
        end
    end

    initial begin
        bus.enc_out   = 1'b0;
        bus.enc_dir   = 1'b0;
        bus.clear     = 1'b0;
        bus.latch_req = 1'b0;
`ifdef QUAD_VELOCITY_EN
        vel_track = 1'b0;
`else
        vel_track = 1'b1;
`endif
        repeat (3) tick();
        push_zero(1, cyc);
        reset = 1'b0;

        // Forward: count unchanged in the toggle cycle, incremented one cycle later.
        for (int i = 1; i <= 10; i++) begin
            bus.enc_dir = 1'b0;
            toggle();
            push_cnt(2, 16'(i - 1), cyc);
            push_cnt(2, 16'(i), cyc + 1);
            repeat (4) tick();
        end

        // Back down to 5, then clear together with a step.
        for (int i = 0; i < 5; i++) begin
            bus.enc_dir = 1'b1;
            toggle();
            repeat (2) tick();
        end
        push_cnt(3, 16'd5, cyc);
        bus.clear   = 1'b1;
        bus.enc_dir = 1'b0;
        toggle();
        push_cnt(4, 16'd0, cyc + 1);
        push_cnt(4, 16'd0, cyc + 2);
        push_cnt(4, 16'd0, cyc + 3);
        tick();
        bus.clear = 1'b0;
        repeat (3) tick();

        // Snapshot with a coincident step.
        for (int i = 0; i < 7; i++) begin
            toggle();
            tick();
        end
        push_cnt(5, 16'd7, cyc);
        toggle();
        bus.latch_req = 1'b1;
        push_latch(6, 16'd7, cyc + 1);
        push_cnt(6, 16'd8, cyc + 1);
        tick();
        bus.latch_req = 1'b0;
        tick();

        // Back-to-back snapshots, then snapshot coincident with clear.
        toggle();
        bus.latch_req = 1'b1;
        push_latch(7, 16'd8, cyc + 1);
        tick();
        toggle();
        push_latch(7, 16'd9, cyc + 1);
        push_cnt(7, 16'd10, cyc + 1);
        tick();
        bus.clear = 1'b1;
        push_latch(8, 16'd10, cyc + 1);
        push_cnt(8, 16'd0, cyc + 1);
        tick();
        bus.clear     = 1'b0;
        bus.latch_req = 1'b0;
        repeat (2) tick();

        // Wrap-around in both directions.
        bus.enc_dir = 1'b0;
        for (int i = 0; i < 32767; i++) begin
            toggle();
            tick();
        end
        push_cnt(9, 16'h7FFF, cyc);
        toggle();
        push_cnt(10, 16'h8000, cyc + 1);
        tick();
        bus.clear = 1'b1;
        push_cnt(11, 16'h0000, cyc + 1);
        tick();
        bus.clear   = 1'b0;
        bus.enc_dir = 1'b1;
        toggle();
        push_cnt(12, 16'hFFFF, cyc + 1);
        repeat (2) tick();

`ifdef QUAD_VELOCITY_EN
        // Clear aligns the window: timer is 0 in cycle c0+1, terminal in c0+VP.
        bus.clear = 1'b1;
        c0 = cyc;
        push_cnt(13, 16'h0000, cyc + 1);
        tick();
        bus.clear   = 1'b0;
        vel_track   = 1'b1;
        bus.enc_dir = 1'b1;
        push_vel(14, 16'hFF9C, c0 + VP + 1);
        for (int i = 0; i < VP; i++) begin
            toggle();
            tick();
        end
        push_cnt(15, 16'hFF9C, cyc);
        push_vel(16, 16'h0000, c0 + 2 * VP + 1);
        repeat (150) tick();

        // Timer is 50 now; reset with a pending snapshot request.
        reset         = 1'b1;
        bus.latch_req = 1'b1;
        bus.enc_out   = 1'b0;
        push_zero(17, cyc + 1);
        push_vel(18, 16'h0000, cyc + 1 + VP);
        tick();
        reset         = 1'b0;
        bus.latch_req = 1'b0;
        repeat (VP + 10) tick();
`else
        reset         = 1'b1;
        bus.latch_req = 1'b1;
        bus.enc_out   = 1'b0;
        push_zero(17, cyc + 1);
        tick();
        reset         = 1'b0;
        bus.latch_req = 1'b0;
        repeat (VP + 10) tick();
`endif

        repeat (3) tick();
        tests++;
        if (cq.size() + lq.size() + vq.size() != 0) begin
            fails++;
            $display("FAIL pending: %0d count, %0d latch, %0d velocity expectations left, want 0",
                     cq.size(), lq.size(), vq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
